// File: rtl/pdm_rx_mc.sv
`default_nettype none
// ============================================================================
// Module   : pdm_rx_mc
// Purpose  : Multi-line, multi-channel PDM receiver front-end. Generates a
//            programmable PDM clock, samples up to NUM_LINES data lines on
//            one or both clock phases, serialises the captured bits as a
//            channel-tagged stream for an external CIC decimator, and
//            buffers the returned PCM samples in a FIFO with a sticky
//            overflow flag.
// Ports    : clk_i, rst_i            - system clock, synchronous active-high reset
//            cfg_*                   - enable, divider, line count, edge mode,
//                                      overflow clear
//            pdm_clk_o, pdm_data_i   - microphone interface
//            bit_o/bit_ch_o/bit_valid_o - serialised bit stream to decimator
//            pcm_i/pcm_ch_i/pcm_valid_i - PCM samples from decimator
//            pcm_data_o/pcm_ch_o/pcm_valid_o/pcm_ready_i - FIFO head, handshake
//            overflow_o              - sticky sample-dropped flag
// Revision : 1.0 - initial release
// ============================================================================
module pdm_rx_mc #(
    parameter int NUM_LINES  = 2,
    parameter int PCM_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 8,
    localparam int CH_W      = $clog2(2 * NUM_LINES),
    localparam int LN_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_clk_div_i,
    input  logic [LN_W-1:0]      cfg_lines_i,
    input  logic                 cfg_dual_edge_i,
    input  logic                 cfg_clr_ovf_i,
    output logic                 pdm_clk_o,
    input  logic [NUM_LINES-1:0] pdm_data_i,
    output logic                 bit_o,
    output logic [CH_W-1:0]      bit_ch_o,
    output logic                 bit_valid_o,
    input  logic [PCM_WIDTH-1:0] pcm_i,
    input  logic [CH_W-1:0]      pcm_ch_i,
    input  logic                 pcm_valid_i,
    output logic [PCM_WIDTH-1:0] pcm_data_o,
    output logic [CH_W-1:0]      pcm_ch_o,
    output logic                 pcm_valid_o,
    input  logic                 pcm_ready_i,
    output logic                 overflow_o
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_ent_w = CH_W + PCM_WIDTH;

    // ------------------------------------------------------------------
    // Effective configuration: last active line index (A-1) and last
    // counter value of a phase (H-1). H is never shorter than A, so a
    // burst always finishes before the next capture.
    // ------------------------------------------------------------------
    int                   w_lines_int;
    int                   w_h_int;
    logic [LN_W-1:0]      w_alast_new;
    logic [DIV_WIDTH-1:0] w_hlast_new;

    always_comb begin
        w_lines_int = int'(cfg_lines_i);
        if (w_lines_int > NUM_LINES - 1) begin
            w_lines_int = NUM_LINES - 1;
        end
        w_h_int = int'(cfg_clk_div_i);
        if (w_h_int < w_lines_int) begin
            w_h_int = w_lines_int;
        end
        w_alast_new = LN_W'(w_lines_int);
        w_hlast_new = DIV_WIDTH'(w_h_int);
    end

    // ------------------------------------------------------------------
    // Clock generator, capture and serialiser
    // ------------------------------------------------------------------
    logic                 r_run;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_hlast;
    logic [LN_W-1:0]      r_alast;
    logic                 r_dual;
    logic                 r_pclk;
    logic [NUM_LINES-1:0] r_cap;
    logic [LN_W-1:0]      r_idx;
    logic [LN_W-1:0]      r_cap_alast;
    logic                 r_busy;
    logic                 r_cap_lo;
    logic                 r_cap_dual;
    logic                 w_term;
    logic                 w_capture;

    assign w_term    = r_run && (r_cnt == r_hlast);
    // High phases are always captured; low phases only in dual-edge mode.
    assign w_capture = w_term && (r_pclk || r_dual);

    always_ff @(posedge clk_i) begin
        if (rst_i || !cfg_en_i) begin
            r_run       <= 1'b0;
            r_cnt       <= '0;
            r_hlast     <= '0;
            r_alast     <= '0;
            r_dual      <= 1'b0;
            r_pclk      <= 1'b0;
            r_cap       <= '0;
            r_idx       <= '0;
            r_cap_alast <= '0;
            r_busy      <= 1'b0;
            r_cap_lo    <= 1'b0;
            r_cap_dual  <= 1'b0;
        end else begin
            r_run <= 1'b1;

            if (r_busy) begin
                if (r_idx == r_cap_alast) begin
                    r_busy <= 1'b0;
                end else begin
                    r_idx <= r_idx + LN_W'(1);
                end
            end

            if (!r_run || w_term) begin
                // Configuration only changes at phase boundaries.
                r_cnt   <= '0;
                r_hlast <= w_hlast_new;
                r_alast <= w_alast_new;
                r_dual  <= cfg_dual_edge_i;
            end else begin
                r_cnt <= r_cnt + DIV_WIDTH'(1);
            end

            if (w_term) begin
                r_pclk <= ~r_pclk;
            end

            // A new capture overrides the final bit of a burst that ends
            // in the terminal cycle itself (A == H).
            if (w_capture) begin
                r_cap       <= pdm_data_i;
                r_idx       <= '0;
                r_busy      <= 1'b1;
                r_cap_lo    <= ~r_pclk;
                r_cap_dual  <= r_dual;
                r_cap_alast <= r_alast;
            end
        end
    end

    assign pdm_clk_o   = r_pclk;
    assign bit_valid_o = r_busy;
    assign bit_o       = r_busy & r_cap[r_idx];
    assign bit_ch_o    = !r_busy    ? '0 :
                         r_cap_dual ? CH_W'({r_idx, r_cap_lo}) :
                                      CH_W'(r_idx);

    // ------------------------------------------------------------------
    // PCM FIFO
    // ------------------------------------------------------------------
    logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_ovf;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [c_ent_w-1:0] w_head;

    assign pcm_valid_o = (r_count != '0);
    assign w_full      = (r_count == (c_ptr_w + 1)'(FIFO_DEPTH));
    assign w_pop       = pcm_valid_o && pcm_ready_i;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign w_push      = pcm_valid_i && (!w_full || w_pop);
    assign w_drop      = pcm_valid_i && w_full && !w_pop;
    assign w_head      = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (!rst_i && cfg_en_i && w_push) begin
            r_mem[r_wptr] <= {pcm_ch_i, pcm_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !cfg_en_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
            // Set has priority over a coincident clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (cfg_clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Head outputs read as zero while the FIFO is empty.
    assign pcm_data_o = pcm_valid_o ? w_head[PCM_WIDTH-1:0] : '0;
    assign pcm_ch_o   = pcm_valid_o ? w_head[c_ent_w-1:PCM_WIDTH] : '0;
    assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pdm_rx_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_rx_mc
// Purpose  : Self-checking bench for pdm_rx_mc. A cycle-stamped behavioural
//            model predicts the PDM clock level, the expected bit stream per
//            cycle and the FIFO contents; directed sequences add literal
//            expectations for the key timing points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_rx_mc;

    localparam int NL = 2;
    localparam int PW = 16;
    localparam int FD = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_en_i = 1'b0;
    logic [DW-1:0] cfg_clk_div_i = '0;
    logic [0:0]    cfg_lines_i = '0;
    logic          cfg_dual_edge_i = 1'b0;
    logic          cfg_clr_ovf_i = 1'b0;
    logic          pdm_clk_o;
    logic [NL-1:0] pdm_data_i = '0;
    logic          bit_o;
    logic [1:0]    bit_ch_o;
    logic          bit_valid_o;
    logic [PW-1:0] pcm_i = '0;
    logic [1:0]    pcm_ch_i = '0;
    logic          pcm_valid_i = 1'b0;
    logic [PW-1:0] pcm_data_o;
    logic [1:0]    pcm_ch_o;
    logic          pcm_valid_o;
    logic          pcm_ready_i = 1'b0;
    logic          overflow_o;

    pdm_rx_mc #(
        .NUM_LINES (NL),
        .PCM_WIDTH (PW),
        .FIFO_DEPTH(FD),
        .DIV_WIDTH (DW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_en_i       (cfg_en_i),
        .cfg_clk_div_i  (cfg_clk_div_i),
        .cfg_lines_i    (cfg_lines_i),
        .cfg_dual_edge_i(cfg_dual_edge_i),
        .cfg_clr_ovf_i  (cfg_clr_ovf_i),
        .pdm_clk_o      (pdm_clk_o),
        .pdm_data_i     (pdm_data_i),
        .bit_o          (bit_o),
        .bit_ch_o       (bit_ch_o),
        .bit_valid_o    (bit_valid_o),
        .pcm_i          (pcm_i),
        .pcm_ch_i       (pcm_ch_i),
        .pcm_valid_i    (pcm_valid_i),
        .pcm_data_o     (pcm_data_o),
        .pcm_ch_o       (pcm_ch_o),
        .pcm_valid_o    (pcm_valid_o),
        .pcm_ready_i    (pcm_ready_i),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase boundaries are tracked as absolute cycle
    // numbers; every capture schedules its bits into a cycle-indexed map.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]    ch;
        logic [PW-1:0] d;
    } ent_t;

    bit   m_run  = 1'b0;
    bit   m_clk  = 1'b0;
    bit   m_dual = 1'b0;
    int   m_a    = 1;
    int   m_h    = 1;
    int   m_term = 0;
    bit   m_ovf  = 1'b0;
    int   exp_bc [int];   // bit*16 + channel, keyed by cycle
    ent_t fq [$];

    task automatic latch_cfg();
        m_a = int'(cfg_lines_i) + 1;
        if (m_a > NL) m_a = NL;
        m_h = int'(cfg_clk_div_i) + 1;
        if (m_h < m_a) m_h = m_a;
        m_dual = cfg_dual_edge_i;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst_i || !cfg_en_i) begin
                m_run = 1'b0;
                m_clk = 1'b0;
                m_ovf = 1'b0;
                exp_bc.delete();
                fq.delete();
            end else begin
                bit   pop;
                bit   push;
                ent_t e;
                if (!m_run) begin
                    m_run = 1'b1;
                    latch_cfg();
                    m_term = cyc + m_h;
                end else if (cyc == m_term) begin
                    if (m_clk || m_dual) begin
                        for (int j = 0; j < m_a; j++) begin
                            int ch;
                            ch = m_dual ? (2 * j + (m_clk ? 0 : 1)) : j;
                            exp_bc[cyc + 1 + j] = int'(pdm_data_i[j]) * 16 + ch;
                        end
                    end
                    m_clk = !m_clk;
                    latch_cfg();
                    m_term = cyc + m_h;
                end
                pop  = (fq.size() > 0) && pcm_ready_i;
                push = pcm_valid_i && ((fq.size() < FD) || pop);
                if (pop) void'(fq.pop_front());
                if (push) begin
                    e.ch = pcm_ch_i;
                    e.d  = pcm_i;
                    fq.push_back(e);
                end
                if (pcm_valid_i && !push) m_ovf = 1'b1;
                else if (cfg_clr_ovf_i) m_ovf = 1'b0;
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("pdm_clk", pdm_clk_o, m_clk);
                if (exp_bc.exists(cyc)) begin
                    chk("bit_valid", bit_valid_o, 1);
                    chk("bit", bit_o, exp_bc[cyc] / 16);
                    chk("bit_ch", bit_ch_o, exp_bc[cyc] % 16);
                    exp_bc.delete(cyc);
                end else begin
                    chk("bit_valid_idle", bit_valid_o, 0);
                end
                chk("pcm_valid", pcm_valid_o, fq.size() > 0);
                if (fq.size() > 0) begin
                    chk("pcm_data", pcm_data_o, fq[0].d);
                    chk("pcm_ch", pcm_ch_o, fq[0].ch);
                end
                chk("overflow", overflow_o, m_ovf);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pdm_clk"}, pdm_clk_o, 0);
        chk({tag, "_bit"}, bit_o, 0);
        chk({tag, "_bit_ch"}, bit_ch_o, 0);
        chk({tag, "_bit_valid"}, bit_valid_o, 0);
        chk({tag, "_pcm_data"}, pcm_data_o, 0);
        chk({tag, "_pcm_ch"}, pcm_ch_o, 0);
        chk({tag, "_pcm_valid"}, pcm_valid_o, 0);
        chk({tag, "_overflow"}, overflow_o, 0);
    endtask

    // Restart with a one-cycle disable; returns in cycle 0 of the new run.
    task automatic restart(input logic [DW-1:0] div, input logic ln, input logic dual);
        step();
        cfg_en_i = 1'b0;
        step();
        cfg_en_i        = 1'b1;
        cfg_clk_div_i   = div;
        cfg_lines_i     = ln;
        cfg_dual_edge_i = dual;
    endtask

    logic [PW-1:0] drain_d [8] = '{16'h1001, 16'h1002, 16'h1003, 16'h1004,
                                   16'h1005, 16'h1006, 16'h1007, 16'hABCD};
    logic [1:0]    drain_c [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

    initial begin
        int w;
        // Reset
        step(); chk_en = 1'b1; step(); step();
        at_neg();
        chk_reset_values("rst");

        // Single-edge, one line, div=3: period 8, one bit per 8 cycles
        step();
        rst_i = 1'b0; cfg_en_i = 1'b1; cfg_clk_div_i = 8'd3;
        cfg_lines_i = 1'b0; cfg_dual_edge_i = 1'b0; pdm_data_i = 2'b01;
        step(); at_neg(); chk("t1_clk_c1", pdm_clk_o, 0);
        repeat (4) step();
        at_neg(); chk("t1_clk_c5", pdm_clk_o, 1);
        repeat (4) step();
        at_neg();
        chk("t1_valid_c9", bit_valid_o, 1);
        chk("t1_bit_c9", bit_o, 1);
        chk("t1_ch_c9", bit_ch_o, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            pdm_data_i = 2'(i / 3);
        end

        // Dual-edge, two lines, div=1, data 2'b10
        restart(8'd1, 1'b1, 1'b1);
        pdm_data_i = 2'b10;
        step(); step(); step(); at_neg();
        chk("t2_bit_c3", bit_o, 0); chk("t2_ch_c3", bit_ch_o, 1);
        step(); at_neg();
        chk("t2_bit_c4", bit_o, 1); chk("t2_ch_c4", bit_ch_o, 3);
        step(); at_neg();
        chk("t2_bit_c5", bit_o, 0); chk("t2_ch_c5", bit_ch_o, 0);
        step(); at_neg();
        chk("t2_bit_c6", bit_o, 1); chk("t2_ch_c6", bit_ch_o, 2);
        repeat (20) step();

        // Divider clamp: div=0, two lines -> H=2, period 4
        restart(8'd0, 1'b1, 1'b0);
        pdm_data_i = 2'b11;
        step(); at_neg(); chk("t3_clk_c1", pdm_clk_o, 0);
        step(); at_neg(); chk("t3_clk_c2", pdm_clk_o, 0);
        step(); at_neg(); chk("t3_clk_c3", pdm_clk_o, 1);
        step(); at_neg(); chk("t3_clk_c4", pdm_clk_o, 1);
        step(); at_neg(); chk("t3_clk_c5", pdm_clk_o, 0);
        for (int i = 0; i < 12; i++) begin step(); pdm_data_i = 2'(i); end
        cfg_dual_edge_i = 1'b1;
        for (int i = 0; i < 12; i++) begin step(); pdm_data_i = 2'(i + 1); end
        cfg_clk_div_i = 8'd5;
        for (int i = 0; i < 30; i++) begin step(); pdm_data_i = 2'(i / 2); end
        cfg_lines_i = 1'b0;
        repeat (20) step();

        // FIFO fill and overflow
        for (int i = 0; i < 9; i++) begin
            step();
            pcm_valid_i = 1'b1; pcm_i = 16'h1000 + 16'(i); pcm_ch_i = 2'(i);
        end
        step(); pcm_valid_i = 1'b0;
        at_neg();
        chk("t4_ovf_set", overflow_o, 1);
        chk("t4_head_data", pcm_data_o, 16'h1000);
        chk("t4_head_ch", pcm_ch_o, 0);
        step(); cfg_clr_ovf_i = 1'b1;
        step(); cfg_clr_ovf_i = 1'b0;
        at_neg(); chk("t4_ovf_clr", overflow_o, 0);
        step();
        pcm_valid_i = 1'b1; pcm_i = 16'hABCD; pcm_ch_i = 2'd3; pcm_ready_i = 1'b1;
        step();
        pcm_valid_i = 1'b0; pcm_ready_i = 1'b0;
        at_neg();
        chk("t4_full_pushpop_ovf", overflow_o, 0);
        chk("t4_full_pushpop_head", pcm_data_o, 16'h1001);
        pcm_valid_i = 1'b1; pcm_i = 16'h5555; cfg_clr_ovf_i = 1'b1;
        step();
        pcm_valid_i = 1'b0; cfg_clr_ovf_i = 1'b0;
        at_neg(); chk("t4_set_beats_clr", overflow_o, 1);
        cfg_clr_ovf_i = 1'b1;
        step(); cfg_clr_ovf_i = 1'b0;
        at_neg(); chk("t4_ovf_clr2", overflow_o, 0);
        pcm_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) at_neg();
            chk("t4_drain_data", pcm_data_o, drain_d[k]);
            chk("t4_drain_ch", pcm_ch_o, drain_c[k]);
        end
        at_neg(); chk("t4_drained", pcm_valid_o, 0);
        pcm_ready_i = 1'b0;

        // Disable mid-burst
        restart(8'd3, 1'b1, 1'b1);
        pcm_valid_i = 1'b1; pcm_i = 16'h7777; pcm_ch_i = 2'd2;
        step(); pcm_valid_i = 1'b0;
        w = 0;
        at_neg();
        while (!bit_valid_o && w < 40) begin at_neg(); w++; end
        chk("t5_burst_seen", bit_valid_o, 1);
        chk("t5_fifo_before", pcm_valid_o, 1);
        cfg_en_i = 1'b0;
        step(); at_neg();
        chk("t5_dis_valid", bit_valid_o, 0);
        chk("t5_dis_clk", pdm_clk_o, 0);
        chk("t5_dis_fifo", pcm_valid_o, 0);
        cfg_en_i = 1'b1;
        pcm_valid_i = 1'b1; pcm_i = 16'h1234; pcm_ch_i = 2'd1;
        step(); pcm_valid_i = 1'b0;
        at_neg(); chk("t5_reen_low", pdm_clk_o, 0);

        // Reset mid-serialisation
        w = 0;
        while (!bit_valid_o && w < 40) begin at_neg(); w++; end
        chk("t6_burst_seen", bit_valid_o, 1);
        rst_i = 1'b1;
        step(); at_neg();
        chk_reset_values("t6");
        rst_i = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
